// File: rtl/usb_ulpi_capture_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_ulpi_capture_framer_pkg
// Purpose : Shared constants, descriptor layout, egress state encoding and
//           the header byte selector for the ULPI capture framer.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package usb_ulpi_capture_framer_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         HDR_LEN    = 8;

    // Bit positions inside the header flags byte
    localparam int         FLAG_TRUNC = 0;
    localparam int         FLAG_HS    = 1;
    localparam int         FLAG_FS    = 2;
    localparam int         FLAG_DROP  = 3;

    localparam int         DESC_BITS  = 51;

    // One queued record: timestamp, committed payload length, per-packet flags
    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] len;
        logic        trunc;
        logic        hs;
        logic        fs;
    } desc_t;

    typedef enum logic [1:0] {
        EG_IDLE = 2'd0,
        EG_HDR  = 2'd1,
        EG_PAY  = 2'd2
    } eg_state_t;

    // Header byte idx of the record described by d; drop is the
    // "drops since previous emitted record" indication.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx,
                                            input desc_t     d,
                                            input logic      drop);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0: b = SYNC_BYTE;
            3'd1: begin
                b[FLAG_TRUNC] = d.trunc;
                b[FLAG_HS]    = d.hs;
                b[FLAG_FS]    = d.fs;
                b[FLAG_DROP]  = drop;
            end
            3'd2: b = d.len[15:8];
            3'd3: b = d.len[7:0];
            3'd4: b = d.ts[31:24];
            3'd5: b = d.ts[23:16];
            3'd6: b = d.ts[15:8];
            3'd7: b = d.ts[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_ulpi_capture_framer_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module  : usb_ulpi_capture_framer_desc_fifo
// Purpose : Synchronous descriptor FIFO, 2^DESC_W entries of WIDTH bits, with
//           show-ahead head output. Push when full and pop when empty are
//           ignored.
// Ports   : clk, rst_n (async active-low), i_push/i_push_data, i_pop,
//           o_head (current head entry), o_full, o_empty
// Revision: 1.0  initial release
// ============================================================================
module usb_ulpi_capture_framer_desc_fifo #(
    parameter int DESC_W = 4,
    parameter int WIDTH  = 51
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 1 << DESC_W;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty
    logic [DESC_W:0]  r_wr_ptr;
    logic [DESC_W:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[DESC_W] != r_rd_ptr[DESC_W]) &&
                       (r_wr_ptr[DESC_W-1:0] == r_rd_ptr[DESC_W-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr[DESC_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[DESC_W-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_ulpi_capture_framer.sv
`default_nettype none
// ============================================================================
// Module  : usb_ulpi_capture_framer
// Purpose : Timestamps packets from the ULPI tap and frames each one as an
//           8-byte header (A5, flags, len, ts) plus payload on a valid/ready
//           byte stream. Store-and-forward through a byte ring and a
//           descriptor FIFO so the header carries the final length.
// Ports   : phy_ulpi_clk   sole clock
//           reset_n        async assert, synchronously released, active-low
//           enable         capture enable, sampled at packet start
//           clear_stats    pulse clearing stat_dropped / stat_overflow
//           ulpi_out_act/byte/latch  tap packet stream
//           stat_hs/stat_fs          link speed, sampled at packet start
//           out_data/valid/ready/last  framed record stream
//           stat_dropped   saturating count of records lost to a full FIFO
//           stat_overflow  sticky: a record was truncated by a full ring
// Revision: 1.0  initial release
// ============================================================================
module usb_ulpi_capture_framer
    import usb_ulpi_capture_framer_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DESC_W = 4
) (
    input  logic        phy_ulpi_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear_stats,
    input  logic        ulpi_out_act,
    input  logic [7:0]  ulpi_out_byte,
    input  logic        ulpi_out_latch,
    input  logic        stat_hs,
    input  logic        stat_fs,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] stat_dropped,
    output logic        stat_overflow
);

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is aligned to
    // the clock so every flop leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Free-running timestamp
    // ------------------------------------------------------------------
    logic [31:0] r_ts;

    always_ff @(posedge phy_ulpi_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ts <= 32'd0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Ingress
    // ------------------------------------------------------------------
    logic              r_act_d;
    logic              r_in_pkt;
    logic [ADDR_W-1:0] r_wr_spec;     // next ring slot for the open packet
    logic [ADDR_W-1:0] r_wr_commit;   // end of the last queued record
    logic [ADDR_W-1:0] r_rd;          // next ring slot to hand to egress
    logic [ADDR_W-1:0] w_wr_inc;
    logic [15:0]       r_len;
    logic              r_trunc;
    logic [31:0]       r_pkt_ts;
    logic              r_pkt_hs;
    logic              r_pkt_fs;
    logic              r_pend_drop;
    logic [15:0]       r_stat_dropped;
    logic              r_stat_overflow;

    logic              w_start;
    logic              w_end;
    logic              w_latch_ok;
    logic              w_ring_full;
    logic              w_ring_we;
    logic              w_trunc_evt;
    logic              w_push;
    logic              w_drop;
    logic              w_flags_load;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    desc_t             w_push_desc;
    desc_t             w_head;

    assign w_start     = ulpi_out_act & ~r_act_d & enable;
    assign w_end       = ~ulpi_out_act & r_act_d & r_in_pkt;
    // A byte latched on the same cycle act rises belongs to the new packet
    assign w_latch_ok  = ulpi_out_latch & ulpi_out_act & (r_in_pkt | w_start);
    assign w_wr_inc    = r_wr_spec + 1'b1;
    assign w_ring_full = (w_wr_inc == r_rd);
    assign w_ring_we   = w_latch_ok & ~w_ring_full;
    assign w_trunc_evt = w_latch_ok & w_ring_full;
    assign w_push      = w_end & (r_len != 16'd0) & ~w_fifo_full;
    assign w_drop      = w_end & (r_len != 16'd0) & w_fifo_full;

    assign w_push_desc = '{ts: r_pkt_ts, len: r_len, trunc: r_trunc,
                           hs: r_pkt_hs, fs: r_pkt_fs};

    always_ff @(posedge phy_ulpi_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_act_d         <= 1'b0;
            r_in_pkt        <= 1'b0;
            r_wr_spec       <= '0;
            r_wr_commit     <= '0;
            r_len           <= 16'd0;
            r_trunc         <= 1'b0;
            r_pkt_ts        <= 32'd0;
            r_pkt_hs        <= 1'b0;
            r_pkt_fs        <= 1'b0;
            r_pend_drop     <= 1'b0;
            r_stat_dropped  <= 16'd0;
            r_stat_overflow <= 1'b0;
        end else begin
            r_act_d <= ulpi_out_act;

            if (w_start) begin
                r_in_pkt <= 1'b1;
                r_pkt_ts <= r_ts;
                r_pkt_hs <= stat_hs;
                r_pkt_fs <= stat_fs;
                r_len    <= {15'd0, w_ring_we};
                r_trunc  <= w_trunc_evt;
            end else begin
                if (w_end) begin
                    r_in_pkt <= 1'b0;
                end
                if (w_ring_we) begin
                    r_len <= r_len + 16'd1;
                end
                if (w_trunc_evt) begin
                    r_trunc <= 1'b1;
                end
            end

            // Ring writes need act=1 and a drop needs act=0: never together
            if (w_drop) begin
                r_wr_spec <= r_wr_commit;
            end else if (w_ring_we) begin
                r_wr_spec <= w_wr_inc;
            end

            if (w_push) begin
                r_wr_commit <= r_wr_spec;
            end

            // The flags byte is formed from r_pend_drop when it is loaded into
            // the output register; drops after that belong to the next record.
            if (w_drop) begin
                r_pend_drop <= 1'b1;
            end else if (w_flags_load) begin
                r_pend_drop <= 1'b0;
            end

            if (clear_stats) begin
                r_stat_dropped <= {15'd0, w_drop};
            end else if (w_drop && (r_stat_dropped != 16'hFFFF)) begin
                r_stat_dropped <= r_stat_dropped + 16'd1;
            end

            if (clear_stats) begin
                r_stat_overflow <= w_trunc_evt;
            end else if (w_trunc_evt) begin
                r_stat_overflow <= 1'b1;
            end
        end
    end

    assign stat_dropped  = r_stat_dropped;
    assign stat_overflow = r_stat_overflow;

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    usb_ulpi_capture_framer_desc_fifo #(
        .DESC_W (DESC_W),
        .WIDTH  (DESC_BITS)
    ) u_desc_fifo (
        .clk         (phy_ulpi_clk),
        .rst_n       (w_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_desc),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Payload ring: simple dual-port RAM with registered read. The read
    // address is the value r_rd takes at this edge, so r_ring_q always holds
    // the byte at r_rd and the output register can take one byte per cycle.
    // ------------------------------------------------------------------
    logic [7:0]        r_ring [1 << ADDR_W];
    logic [7:0]        r_ring_q;
    logic [ADDR_W-1:0] w_rd_next;
    logic              w_rd_adv;

    assign w_rd_next = r_rd + {{(ADDR_W-1){1'b0}}, w_rd_adv};

    always_ff @(posedge phy_ulpi_clk) begin
        if (w_ring_we) begin
            r_ring[r_wr_spec] <= ulpi_out_byte;
        end
        r_ring_q <= r_ring[w_rd_next];
    end

    // ------------------------------------------------------------------
    // Egress FSM. out_data/out_valid/out_last are registers loaded whenever
    // the register is empty or its byte is being accepted (w_take). r_rd
    // moves as payload bytes are copied into the output register, which
    // frees their ring slot.
    // ------------------------------------------------------------------
    eg_state_t   r_state;
    logic [2:0]  r_idx;        // next header byte to load
    logic [15:0] r_remain;     // payload bytes still to load
    logic        w_take;

    assign w_take       = ~out_valid | out_ready;
    assign w_flags_load = (r_state == EG_HDR) & w_take & (r_idx == 3'd1);
    assign w_rd_adv     = (r_state == EG_PAY) & w_take;
    // The descriptor is no longer needed once its last byte is loaded
    assign w_pop        = w_rd_adv & (r_remain == 16'd1);

    always_ff @(posedge phy_ulpi_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= EG_IDLE;
            r_idx     <= 3'd0;
            r_remain  <= 16'd0;
            r_rd      <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            r_rd <= w_rd_next;
            case (r_state)
                EG_IDLE: begin
                    if (w_take) begin
                        out_last <= 1'b0;
                        if (!w_fifo_empty) begin
                            out_data  <= SYNC_BYTE;
                            out_valid <= 1'b1;
                            r_idx     <= 3'd1;
                            r_state   <= EG_HDR;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                EG_HDR: begin
                    if (w_take) begin
                        out_data <= hdr_byte(r_idx, w_head, r_pend_drop);
                        if (r_idx == 3'(HDR_LEN - 1)) begin
                            r_remain <= w_head.len;
                            r_state  <= EG_PAY;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                EG_PAY: begin
                    if (w_take) begin
                        out_data <= r_ring_q;
                        r_remain <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            out_last <= 1'b1;
                            r_state  <= EG_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= EG_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_ulpi_capture_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_usb_ulpi_capture_framer
// Purpose : Directed self-checking bench for usb_ulpi_capture_framer
//           (ADDR_W=4, DESC_W=1 instance).
// Revision: 1.0  initial release
// ============================================================================
module tb_usb_ulpi_capture_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear_stats;
    logic        act;
    logic [7:0]  ubyte;
    logic        latch;
    logic        hs;
    logic        fs;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] stat_dropped;
    logic        stat_overflow;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] tb_cyc;
    logic [8:0]  rx[$];
    logic [8:0]  ex[$];
    logic [7:0]  pb[$];
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_word  = 9'h0;

    usb_ulpi_capture_framer #(
        .ADDR_W (4),
        .DESC_W (1)
    ) dut (
        .phy_ulpi_clk   (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear_stats    (clear_stats),
        .ulpi_out_act   (act),
        .ulpi_out_byte  (ubyte),
        .ulpi_out_latch (latch),
        .stat_hs        (hs),
        .stat_fs        (fs),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .stat_dropped   (stat_dropped),
        .stat_overflow  (stat_overflow)
    );

    always #8 clk = ~clk;

    // Edges since reset release; the DUT timestamp lags this by two because
    // of its reset release synchroniser.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 32'd0;
        else          tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collect accepted bytes and check held data while stalled
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, prev_word});
            end
            if (out_valid && out_ready) rx.push_back({out_last, out_data});
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic p_hs, input logic p_fs,
                            input logic clr, output logic [31:0] ts_exp);
        ts_exp = 32'd0;
        for (int i = 0; i < n; i++) begin
            tick();
            act = 1'b1; latch = 1'b1; ubyte = pb[i];
            if (i == 0) begin
                hs = p_hs; fs = p_fs;
                ts_exp = tb_cyc - 32'd2;
            end
        end
        tick();
        act = 1'b0; latch = 1'b0; ubyte = 8'h00; clear_stats = clr;
    endtask

    task automatic add_rec(input logic [31:0] ts, input logic [7:0] flags, input int n);
        logic [15:0] l;
        l = n[15:0];
        ex.push_back({1'b0, 8'hA5});
        ex.push_back({1'b0, flags});
        ex.push_back({1'b0, l[15:8]});
        ex.push_back({1'b0, l[7:0]});
        ex.push_back({1'b0, ts[31:24]});
        ex.push_back({1'b0, ts[23:16]});
        ex.push_back({1'b0, ts[15:8]});
        ex.push_back({1'b0, ts[7:0]});
        for (int i = 0; i < n; i++) ex.push_back({(i == n - 1), pb[i]});
    endtask

    // mode 0: out_ready=1, mode 1: out_ready random 50%
    task automatic drain_check(input string tag, input int mode);
        int cyc;
        cyc = 0;
        while (rx.size() < ex.size() && cyc < 600) begin
            tick();
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        out_ready = 1'b1;
        repeat (3) tick();
        chk({tag, "_count"}, rx.size(), ex.size());
        for (int i = 0; i < ex.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < rx.size()) ? {23'd0, rx[i]} : 32'hDEAD, {23'd0, ex[i]});
        end
        ex.delete();
        rx.delete();
    endtask

    initial begin
        logic [31:0] t1, t2, tdummy;
        int guard;

        reset_n = 1'b0; enable = 1'b1; clear_stats = 1'b0; act = 1'b0;
        ubyte = 8'h00; latch = 1'b0; hs = 1'b0; fs = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  {24'd0, out_data}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_drop",  {16'd0, stat_dropped}, 32'd0);
        chk("rst_ovf",   {31'd0, stat_overflow}, 32'd0);
        reset_n = 1'b1;

        // T1: 3 bytes, hs, ts 0x100, header valid two cycles after act falls
        guard = 0;
        while (tb_cyc != 32'h101 && guard < 1000) begin tick(); guard++; end
        pb = '{8'h2D, 8'h00, 8'h10};
        send_pkt(3, 1'b1, 1'b0, 1'b0, tdummy);
        tick();
        tick();
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        pb = '{8'h2D, 8'h00, 8'h10};
        add_rec(32'h0000_0100, 8'h02, 3);
        drain_check("t1", 0);

        // T2: 2-byte then 1-byte packet, one idle cycle between, fs=1
        pb = '{8'h11, 8'h22};
        send_pkt(2, 1'b0, 1'b1, 1'b0, t1);
        pb = '{8'h33};
        send_pkt(1, 1'b0, 1'b1, 1'b0, t2);
        pb = '{8'h11, 8'h22};
        add_rec(t1, 8'h04, 2);
        pb = '{8'h33};
        add_rec(t2, 8'h04, 1);
        drain_check("t2", 0);

        // T3: 20 bytes into a 15-byte ring -> truncated record
        pb.delete();
        for (int i = 0; i < 20; i++) pb.push_back(8'(8'h60 + i));
        send_pkt(20, 1'b0, 1'b0, 1'b0, t1);
        tick();
        chk("t3_overflow", {31'd0, stat_overflow}, 32'd1);
        add_rec(t1, 8'h01, 15);
        drain_check("t3", 0);
        tick(); clear_stats = 1'b1;
        tick();
        tick();
        chk("t3_ovf_clear", {31'd0, stat_overflow}, 32'd0);

        // T4: consumer stalled, FIFO of two fills, third and fourth dropped;
        // fourth drop coincides with clear_stats
        out_ready = 1'b0;
        pb = '{8'h41};
        send_pkt(1, 1'b0, 1'b0, 1'b0, t1);
        pb = '{8'h42};
        send_pkt(1, 1'b0, 1'b0, 1'b0, t2);
        pb = '{8'h43};
        send_pkt(1, 1'b0, 1'b0, 1'b0, tdummy);
        tick();
        chk("t4_dropped", {16'd0, stat_dropped}, 32'd1);
        pb = '{8'h44};
        send_pkt(1, 1'b0, 1'b0, 1'b1, tdummy);
        tick();
        chk("t4_clr_drop", {16'd0, stat_dropped}, 32'd1);
        pb = '{8'h41};
        add_rec(t1, 8'h08, 1);
        pb = '{8'h42};
        add_rec(t2, 8'h00, 1);
        drain_check("t4", 1);

        // T5: act pulse without latch, and a packet while disabled
        for (int i = 0; i < 3; i++) begin tick(); act = 1'b1; end
        tick(); act = 1'b0;
        enable = 1'b0;
        pb = '{8'h55, 8'h66};
        send_pkt(2, 1'b0, 1'b0, 1'b0, tdummy);
        enable = 1'b1;
        repeat (20) tick();
        chk("t5_no_rec", rx.size(), 32'd0);
        chk("t5_idle", {31'd0, out_valid}, 32'd0);

        // T6: reset in the middle of a payload, then a clean record
        out_ready = 1'b0;
        pb.delete();
        for (int i = 0; i < 10; i++) pb.push_back(8'(8'h80 + i));
        send_pkt(10, 1'b1, 1'b0, 1'b0, tdummy);
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin tick(); out_ready = 1'b1; end
        chk("t6_busy", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_drop",  {16'd0, stat_dropped}, 32'd0);
        chk("t6_rst_ovf",   {31'd0, stat_overflow}, 32'd0);
        repeat (3) tick();
        rx.delete();
        reset_n = 1'b1;
        repeat (4) tick();
        pb = '{8'hC1, 8'hC2};
        send_pkt(2, 1'b0, 1'b1, 1'b0, t1);
        add_rec(t1, 8'h04, 2);
        drain_check("t6", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
